// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: divide-timer state
// encoding, stall cause codes and the default divide latency.
package hazard_ctrl_pkg;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_LU   = 2'b01,
        CAUSE_BR   = 2'b10,
        CAUSE_DV   = 2'b11
    } stall_cause_t;

    localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle; the hazard unit is the slave side.
interface hazard_ctrl_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_UseRt;
    logic        ID_Branch;
    logic        ID_Mflo;
    logic        ID_Mfhi;
    logic        ID_MulDiv;
    logic        EX_MemRead;
    logic        EX_RegWrite;
    logic [4:0]  EX_waddr;
    logic        MEM_MemRead;
    logic [4:0]  MEM_waddr;
    logic        EX_DivStart;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        ID_EX_Bubble;
    logic        div_busy;
    logic [1:0]  stall_cause;
    logic [15:0] stall_cnt;

    modport master (
        output ID_rs, ID_rt, ID_UseRt, ID_Branch, ID_Mflo, ID_Mfhi, ID_MulDiv,
               EX_MemRead, EX_RegWrite, EX_waddr, MEM_MemRead, MEM_waddr, EX_DivStart,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, div_busy, stall_cause, stall_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UseRt, ID_Branch, ID_Mflo, ID_Mfhi, ID_MulDiv,
               EX_MemRead, EX_RegWrite, EX_waddr, MEM_MemRead, MEM_waddr, EX_DivStart,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, div_busy, stall_cause, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_div_busy_timer.sv
// Tracks how long HI/LO stays unavailable after a divide enters EX.
module div_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic div_start,
    output logic div_busy
);

    div_state_t state;
    logic [7:0] cnt;

    // A start pulse arriving while BUSY cannot happen legally; it is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= DIV_IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_start) begin
                        cnt   <= 8'(DIV_CYCLES - 1);
                        state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= DIV_IDLE;
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // The start cycle itself counts as busy, giving exactly DIV_CYCLES cycles.
    assign div_busy = div_start || (state == DIV_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard detection: load-use, branch-operand and HI/LO divide stalls,
// with a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    logic         div_busy;
    logic         lu_haz;
    logic         br_haz;
    logic         dv_haz;
    logic         stall;
    logic [15:0]  stall_cnt;
    stall_cause_t cause;

    function automatic logic src_match(input logic [4:0] x, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rt);
        return (x != 5'd0) && ((x == rs) || (use_rt && (x == rt)));
    endfunction

    div_busy_timer #(.DIV_CYCLES(DIV_CYCLES)) u_div_timer (
        .clock     (clock),
        .reset     (reset),
        .div_start (bus.EX_DivStart),
        .div_busy  (div_busy)
    );

    always_comb begin
        lu_haz = bus.EX_MemRead && src_match(bus.EX_waddr, bus.ID_rs, bus.ID_rt, bus.ID_UseRt);
        br_haz = bus.ID_Branch &&
                 ((bus.EX_RegWrite && src_match(bus.EX_waddr, bus.ID_rs, bus.ID_rt, bus.ID_UseRt)) ||
                  (bus.MEM_MemRead && src_match(bus.MEM_waddr, bus.ID_rs, bus.ID_rt, bus.ID_UseRt)));
        dv_haz = div_busy && (bus.ID_Mflo || bus.ID_Mfhi || bus.ID_MulDiv);
        stall  = lu_haz || br_haz || dv_haz;
        cause  = CAUSE_NONE;
        if (lu_haz) begin
            cause = CAUSE_LU;
        end else if (br_haz) begin
            cause = CAUSE_BR;
        end else if (dv_haz) begin
            cause = CAUSE_DV;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.PCWrite      = !stall;
    assign bus.IF_ID_Write  = !stall;
    assign bus.ID_EX_Bubble = stall;
    assign bus.div_busy     = div_busy;
    assign bus.stall_cause  = cause;
    assign bus.stall_cnt    = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-indexed model.
module tb_hazard_ctrl;
    localparam int DIV_CYCLES = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: divide window is [start, start+DIV_CYCLES) in absolute cycle numbers.
    int          m_cyc = 0;
    int          m_busy_end = 0;
    int          m_cnt = 0;

    function automatic bit mm(input logic [4:0] x);
        return (x != 0) && (x == hif.ID_rs || (hif.ID_UseRt && x == hif.ID_rt));
    endfunction

    always @(negedge clock) begin
        bit m_busy, m_lu, m_br, m_dv, m_stall;
        int m_cause;
        if (!reset) begin
            m_cnt      = 0;
            m_busy_end = 0;
        end
        m_busy  = hif.EX_DivStart || (reset && m_cyc < m_busy_end);
        m_lu    = hif.EX_MemRead && mm(hif.EX_waddr);
        m_br    = hif.ID_Branch && ((hif.EX_RegWrite && mm(hif.EX_waddr)) ||
                                    (hif.MEM_MemRead && mm(hif.MEM_waddr)));
        m_dv    = m_busy && (hif.ID_Mflo || hif.ID_Mfhi || hif.ID_MulDiv);
        m_stall = m_lu || m_br || m_dv;
        m_cause = m_lu ? 1 : m_br ? 2 : m_dv ? 3 : 0;
        chk("m_pcwrite", 32'(hif.PCWrite), 32'(!m_stall));
        chk("m_ifid", 32'(hif.IF_ID_Write), 32'(!m_stall));
        chk("m_bubble", 32'(hif.ID_EX_Bubble), 32'(m_stall));
        chk("m_divbusy", 32'(hif.div_busy), 32'(m_busy));
        chk("m_cause", 32'(hif.stall_cause), 32'(m_cause));
        chk("m_stallcnt", 32'(hif.stall_cnt), 32'(m_cnt));
        if (reset) begin
            if (hif.EX_DivStart && !(m_cyc < m_busy_end)) m_busy_end = m_cyc + DIV_CYCLES;
            if (m_stall && m_cnt < 65535) m_cnt++;
        end
        m_cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        hif.ID_rs = 0; hif.ID_rt = 0; hif.ID_UseRt = 0; hif.ID_Branch = 0;
        hif.ID_Mflo = 0; hif.ID_Mfhi = 0; hif.ID_MulDiv = 0;
        hif.EX_MemRead = 0; hif.EX_RegWrite = 0; hif.EX_waddr = 0;
        hif.MEM_MemRead = 0; hif.MEM_waddr = 0; hif.EX_DivStart = 0;
    endtask

    initial begin
        idle();
        repeat (3) step();
        chk("rst_stallcnt", 32'(hif.stall_cnt), 0);
        chk("rst_divbusy", 32'(hif.div_busy), 0);
        chk("rst_pcwrite", 32'(hif.PCWrite), 1);
        chk("rst_cause", 32'(hif.stall_cause), 0);
        reset = 1'b1;
        step();

        // Load-use
        hif.EX_MemRead = 1; hif.EX_waddr = 8; hif.ID_rs = 8;
        #1;
        chk("lu_pcwrite", 32'(hif.PCWrite), 0);
        chk("lu_bubble", 32'(hif.ID_EX_Bubble), 1);
        chk("lu_cause", 32'(hif.stall_cause), 1);
        step();
        hif.EX_waddr = 0; hif.ID_rs = 0;
        #1;
        chk("lu_r0_pcwrite", 32'(hif.PCWrite), 1);
        chk("lu_cnt", 32'(hif.stall_cnt), 1);
        step();

        // Branch: EX producer then MEM load
        idle();
        hif.ID_Branch = 1; hif.ID_rt = 9; hif.ID_UseRt = 1; hif.EX_RegWrite = 1; hif.EX_waddr = 9;
        #1;
        chk("br_ex_cause", 32'(hif.stall_cause), 2);
        chk("br_ex_pcwrite", 32'(hif.PCWrite), 0);
        step();
        hif.EX_RegWrite = 0; hif.EX_waddr = 0; hif.MEM_MemRead = 1; hif.MEM_waddr = 9;
        #1;
        chk("br_mem_cause", 32'(hif.stall_cause), 2);
        step();
        idle();
        #1;
        chk("br_cnt", 32'(hif.stall_cnt), 3);
        step();

        // Divide window with Mflo held
        hif.EX_DivStart = 1; hif.ID_Mflo = 1;
        #1;
        chk("dv_cause0", 32'(hif.stall_cause), 3);
        step();
        hif.EX_DivStart = 0;
        for (int i = 1; i < DIV_CYCLES; i++) begin
            #1;
            chk("dv_stall", 32'(hif.PCWrite), 0);
            step();
        end
        #1;
        chk("dv_release", 32'(hif.PCWrite), 1);
        chk("dv_cnt", 32'(hif.stall_cnt), 35);
        step();

        // All three hazards at once
        idle();
        hif.EX_DivStart = 1; hif.ID_MulDiv = 1; hif.ID_rs = 8; hif.EX_MemRead = 1;
        hif.EX_RegWrite = 1; hif.EX_waddr = 8; hif.ID_Branch = 1;
        #1;
        chk("prio_cause", 32'(hif.stall_cause), 1);
        step();
        idle();
        #1;
        chk("prio_cnt", 32'(hif.stall_cnt), 36);
        repeat (35) step();

        // Reset in the middle of a divide
        hif.EX_DivStart = 1; hif.ID_Mfhi = 1;
        step();
        hif.EX_DivStart = 0;
        repeat (9) step();
        reset = 1'b0;
        #1;
        chk("rstdiv_busy", 32'(hif.div_busy), 0);
        chk("rstdiv_cnt", 32'(hif.stall_cnt), 0);
        step();
        reset = 1'b1;
        #1;
        chk("rstdiv_after", 32'(hif.div_busy), 0);
        chk("rstdiv_pcwrite", 32'(hif.PCWrite), 1);
        step();
        hif.EX_DivStart = 1;
        #1;
        chk("restart_busy", 32'(hif.div_busy), 1);
        step();
        hif.EX_DivStart = 0;
        for (int i = 1; i < DIV_CYCLES; i++) begin
            #1;
            chk("restart_stall", 32'(hif.PCWrite), 0);
            step();
        end
        #1;
        chk("restart_release", 32'(hif.PCWrite), 1);
        chk("restart_cnt", 32'(hif.stall_cnt), 32);
        idle();
        step();

        // Randomized traffic, including illegal starts while busy and short resets
        for (int i = 0; i < 2000; i++) begin
            hif.ID_rs       = 5'($urandom_range(0, 3));
            hif.ID_rt       = 5'($urandom_range(0, 3));
            hif.ID_UseRt    = 1'($urandom_range(0, 1));
            hif.ID_Branch   = 1'($urandom_range(0, 1));
            hif.ID_Mflo     = ($urandom_range(0, 3) == 0);
            hif.ID_Mfhi     = ($urandom_range(0, 3) == 0);
            hif.ID_MulDiv   = ($urandom_range(0, 3) == 0);
            hif.EX_MemRead  = ($urandom_range(0, 2) == 0);
            hif.EX_RegWrite = 1'($urandom_range(0, 1));
            hif.EX_waddr    = 5'($urandom_range(0, 3));
            hif.MEM_MemRead = ($urandom_range(0, 2) == 0);
            hif.MEM_waddr   = 5'($urandom_range(0, 3));
            hif.EX_DivStart = ($urandom_range(0, 19) == 0);
            reset           = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1;
        idle();
        step();

        // Saturation under a held load-use stall
        hif.EX_MemRead = 1; hif.EX_waddr = 5; hif.ID_rs = 5;
        repeat (70000) step();
        chk("sat_cnt", 32'(hif.stall_cnt), 32'hFFFF);
        step();
        chk("sat_hold", 32'(hif.stall_cnt), 32'hFFFF);
        chk("sat_pcwrite", 32'(hif.PCWrite), 0);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
